vec_address_scheduler: RTL and testbench



---
 rtl/vec_address_scheduler_pkg.sv | 52 +++++
 rtl/vec_lane_picker.sv | 48 ++++
 rtl/vec_address_scheduler.sv | 175 +++++++++++++++++
 tb/tb_vec_address_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_address_scheduler_pkg.sv
// vec_address_scheduler_pkg: element-width encoding, scheduler states and the
// byte-mask / alignment helpers shared by the scheduler and its lane picker.
package vec_address_scheduler_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'd0,
    SEW_16  = 2'd1,
    SEW_32  = 2'd2,
    SEW_RSV = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  // Byte lanes of the 32-bit cache word touched by one element.
  function automatic logic [3:0] sew_byte_mask(input sew_e s, input logic [1:0] off);
    logic [3:0] m;
    case (s)
      SEW_8:   m = 4'b0001 << off;
      SEW_16:  m = off[1] ? 4'b1100 : 4'b0011;
      SEW_32:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] sew_elem_mask(input sew_e s);
    logic [31:0] m;
    case (s)
      SEW_8:   m = 32'h0000_00FF;
      SEW_16:  m = 32'h0000_FFFF;
      SEW_32:  m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input sew_e s, input logic [1:0] off);
    logic bad;
    case (s)
      SEW_8:   bad = 1'b0;
      SEW_16:  bad = off[0];
      SEW_32:  bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/vec_lane_picker.sv
// vec_lane_picker: picks the lowest pending lane and the set of lanes served by
// its access. Same-word coalescing is built when VEC_ADDR_SCHED_COALESCE_EN is defined.
module vec_lane_picker #(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0]       i_pending,
  input  logic [LANES-1:0][29:0] i_word,
  input  logic [LANES-1:0][3:0]  i_mask,
  output logic                   o_found,
  output logic [29:0]            o_word,
  output logic [LANES-1:0]       o_group,
  output logic [3:0]             o_byte_ena
);

  logic             w_found;
  logic [29:0]      w_word;
  logic [LANES-1:0] w_group;
  logic [3:0]       w_byte_ena;

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path can infer a latch.
    w_found    = 1'b0;
    w_word     = '0;
    w_group    = '0;
    w_byte_ena = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i_pending[i] && !w_found) begin
        w_found    = 1'b1;
        w_word     = i_word[i];
        w_group[i] = 1'b1;
        w_byte_ena = i_mask[i];
      end
`ifdef VEC_ADDR_SCHED_COALESCE_EN
      // Later lanes join only if they hit the leader's word without overlapping bytes.
      else if (i_pending[i] && i_word[i] == w_word && (i_mask[i] & w_byte_ena) == 4'b0000) begin
        w_group[i] = 1'b1;
        w_byte_ena = w_byte_ena | i_mask[i];
      end
`endif
    end
  end

  assign o_found    = w_found;
  assign o_word     = w_word;
  assign o_group    = w_group;
  assign o_byte_ena = w_byte_ena;

endmodule

// File: rtl/vec_address_scheduler.sv
// vec_address_scheduler: captures one LANES-wide vector load/store group and
// serialises it onto a single 32-bit dcache port, one outstanding access at a time.
module vec_address_scheduler
  import vec_address_scheduler_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic                       load_ena,
  input  logic                       store_ena,
  input  logic [1:0]                 sew,
  input  logic [LANES-1:0]           lane_en,
  input  logic [LANES*32-1:0]        addr,
  input  logic [LANES*32-1:0]        storedata,
  input  logic                       returnex,
  input  logic                       dhit,
  input  logic [31:0]                dload,
  output logic [31:0]                final_addr,
  output logic [31:0]                final_storedata,
  output logic [3:0]                 byte_ena,
  output logic                       ren,
  output logic                       wen,
  output logic [LANES*32-1:0]        loaddata,
  output logic [LANES-1:0]           arrived,
  output logic                       busy,
  output logic                       done,
  output logic                       exception,
  output logic [$clog2(LANES)-1:0]   exc_lane
);

  localparam int IDX_W = $clog2(LANES);

  state_e                 r_state;
  logic                   r_op_load;
  logic                   r_op_store;
  sew_e                   r_sew;
  logic [LANES-1:0]       r_lane_en;
  logic [LANES-1:0]       r_arrived;
  logic [LANES-1:0][31:0] r_addr;
  logic [LANES-1:0][31:0] r_storedata;
  logic [LANES-1:0][31:0] r_loaddata;
  logic                   r_done;
  logic                   r_exception;
  logic [IDX_W-1:0]       r_exc_lane;

  sew_e                   w_in_sew;
  logic [LANES-1:0]       w_start_misalign;
  logic [IDX_W-1:0]       w_start_exc_lane;
  logic [LANES-1:0]       w_pending;
  logic [LANES-1:0][29:0] w_word;
  logic [LANES-1:0][3:0]  w_mask;
  logic [LANES-1:0][31:0] w_load_elem;
  logic [31:0]            w_store_word;
  logic                   w_found;
  logic [29:0]            w_lead_word;
  logic [LANES-1:0]       w_group;
  logic [3:0]             w_byte_ena;
  logic                   w_access;

  assign w_in_sew = sew_e'(sew);

  // Misalignment is judged on the values being captured; the lowest enabled offender is reported.
  always_comb begin
    w_start_misalign = '0;
    w_start_exc_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      w_start_misalign[i] = lane_en[i] && is_misaligned(w_in_sew, addr[32*i +: 2]);
      if (w_start_misalign[i]) w_start_exc_lane = IDX_W'(i);
    end
  end

  assign w_pending = r_lane_en & ~r_arrived;

  always_comb begin
    w_word       = '0;
    w_mask       = '0;
    w_load_elem  = '0;
    w_store_word = '0;
    for (int i = 0; i < LANES; i++) begin
      w_word[i]      = r_addr[i][31:2];
      w_mask[i]      = sew_byte_mask(r_sew, r_addr[i][1:0]);
      w_load_elem[i] = (dload >> {r_addr[i][1:0], 3'b000}) & sew_elem_mask(r_sew);
      if (w_group[i])
        w_store_word = w_store_word
                     | ((r_storedata[i] & sew_elem_mask(r_sew)) << {r_addr[i][1:0], 3'b000});
    end
  end

  vec_lane_picker #(.LANES(LANES)) u_picker (
    .i_pending  (w_pending),
    .i_word     (w_word),
    .i_mask     (w_mask),
    .o_found    (w_found),
    .o_word     (w_lead_word),
    .o_group    (w_group),
    .o_byte_ena (w_byte_ena)
  );

  assign w_access        = (r_state == ST_ACCESS) && w_found;
  assign final_addr      = w_access ? {w_lead_word, 2'b00} : 32'h0;
  assign byte_ena        = w_access ? w_byte_ena : 4'b0000;
  assign final_storedata = w_access ? w_store_word : 32'h0;
  assign ren             = w_access & r_op_load;
  assign wen             = w_access & r_op_store;
  assign loaddata        = r_loaddata;
  assign arrived         = r_arrived;
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;
  assign exception       = r_exception;
  assign exc_lane        = r_exc_lane;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: captured operands are reset as well so every output reads zero straight out of reset.
      r_state     <= ST_IDLE;
      r_op_load   <= 1'b0;
      r_op_store  <= 1'b0;
      r_sew       <= SEW_8;
      r_lane_en   <= '0;
      r_arrived   <= '0;
      r_addr      <= '0;
      r_storedata <= '0;
      r_loaddata  <= '0;
      r_done      <= 1'b0;
      r_exception <= 1'b0;
      r_exc_lane  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_done      <= 1'b0;
      r_exception <= 1'b0;
      r_exc_lane  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op_load   <= load_ena;
            r_op_store  <= store_ena;
            r_sew       <= w_in_sew;
            r_lane_en   <= lane_en;
            r_addr      <= addr;
            r_storedata <= storedata;
            r_arrived   <= '0;
            r_loaddata  <= '0;
            if (|w_start_misalign) begin
              r_state     <= ST_ERROR;
              r_exception <= 1'b1;
              r_exc_lane  <= w_start_exc_lane;
            end else if (lane_en == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (returnex) begin
            r_state <= ST_IDLE;
          end else if (dhit) begin
            r_arrived <= r_arrived | w_group;
            for (int i = 0; i < LANES; i++)
              if (w_group[i] && r_op_load) r_loaddata[i] <= w_load_elem[i];
            if ((r_arrived | w_group) == r_lane_en) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_ERROR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_address_scheduler.sv
// tb_vec_address_scheduler: table vectors, hand-written abort/reset sequences and
// random groups checked against a byte-level model of the scheduler's behaviour.
module tb_vec_address_scheduler;

  localparam int LANES = 4;
  localparam int IW    = $clog2(LANES);
`ifdef VEC_ADDR_SCHED_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST, start, load_ena, store_ena, returnex, dhit;
  logic [1:0]            sew;
  logic [LANES-1:0]      lane_en;
  logic [LANES*32-1:0]   addr, storedata;
  logic [31:0]           dload;
  logic [31:0]           final_addr, final_storedata;
  logic [3:0]            byte_ena;
  logic                  ren, wen, busy, done, exception;
  logic [LANES*32-1:0]   loaddata;
  logic [LANES-1:0]      arrived;
  logic [IW-1:0]         exc_lane;

  int n_tests = 0;
  int n_fail  = 0;

  vec_address_scheduler #(.LANES(LANES)) dut (
    .CLK(CLK), .RST(RST), .start(start), .load_ena(load_ena), .store_ena(store_ena),
    .sew(sew), .lane_en(lane_en), .addr(addr), .storedata(storedata),
    .returnex(returnex), .dhit(dhit), .dload(dload),
    .final_addr(final_addr), .final_storedata(final_storedata), .byte_ena(byte_ena),
    .ren(ren), .wen(wen), .loaddata(loaddata), .arrived(arrived),
    .busy(busy), .done(done), .exception(exception), .exc_lane(exc_lane)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Cache contents: a fixed byte pattern derived from the byte address.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return {mem_byte(wa + 32'd3), mem_byte(wa + 32'd2), mem_byte(wa + 32'd1), mem_byte(wa)};
  endfunction

  // Reference model results for the current group.
  logic [31:0]            m_addr[$];
  logic [3:0]             m_be[$];
  logic [31:0]            m_sd[$];
  logic [LANES-1:0][31:0] m_load;
  bit                     m_exc;
  int                     m_exc_lane;

  task automatic model(input bit is_load, input logic [1:0] s, input logic [LANES-1:0] en,
                       input logic [LANES-1:0][31:0] a, input logic [LANES-1:0][31:0] sd);
    int size;
    int l;
    logic [LANES-1:0] pend;
    logic [3:0] acc, lm;
    logic [31:0] w, ba;
    m_addr.delete(); m_be.delete(); m_sd.delete();
    m_load = '0; m_exc = 1'b0; m_exc_lane = 0;
    size = 1 << s;
    for (int i = LANES - 1; i >= 0; i--)
      if (en[i] && (s == 2'd3 || (a[i] % size) != 0)) begin
        m_exc = 1'b1;
        m_exc_lane = i;
      end
    if (m_exc) return;
    pend = en;
    while (pend != '0) begin
      l = -1;
      for (int i = 0; i < LANES; i++) if (pend[i] && l < 0) l = i;
      acc = '0; w = '0;
      for (int i = l; i < LANES; i++) begin
        if (!pend[i]) continue;
        if (i != l && (!COALESCE || a[i][31:2] != a[l][31:2])) continue;
        lm = '0;
        for (int b = 0; b < size; b++) begin
          ba = a[i] + 32'(b);
          lm[ba[1:0]] = 1'b1;
        end
        if (i != l && (lm & acc) != 4'b0000) continue;
        acc = acc | lm;
        pend[i] = 1'b0;
        for (int b = 0; b < size; b++) begin
          ba = a[i] + 32'(b);
          w[{ba[1:0], 3'b000} +: 8] = sd[i][8*b +: 8];
          if (is_load) m_load[i][8*b +: 8] = mem_byte(ba);
        end
      end
      m_addr.push_back({a[l][31:2], 2'b00});
      m_be.push_back(acc);
      m_sd.push_back(w);
    end
  endtask

  // Drives one group, plays the cache with a fixed hit delay and compares everything.
  task automatic run_group(input string name, input bit is_load, input logic [1:0] s,
                           input logic [LANES-1:0] en, input logic [LANES-1:0][31:0] a,
                           input logic [LANES-1:0][31:0] sd, input int dly, input int exp_n,
                           input bit poke);
    int k, wait_cnt, lat;
    bit seen_done;
    model(is_load, s, en, a, sd);
    load_ena = is_load; store_ena = !is_load; sew = s; lane_en = en;
    addr = a; storedata = sd; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    if (m_exc) begin
      check({name, ".exception"}, exception, 1'b1);
      check({name, ".exc_lane"}, exc_lane, m_exc_lane);
      check({name, ".no_req"}, {ren, wen}, 2'b00);
      tick();
      check({name, ".exc_end"}, {exception, busy, ren, wen, done}, 5'b0);
      return;
    end
    k = 0; wait_cnt = 0; seen_done = 1'b0;
    while (lat < 400) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (ren || wen) begin
        if (k >= m_addr.size()) begin
          check({name, ".extra_access"}, {ren, wen}, 2'b00);
          break;
        end
        if (wait_cnt == 0) begin
          check({name, ".final_addr"}, final_addr, m_addr[k]);
          check({name, ".byte_ena"}, byte_ena, m_be[k]);
          check({name, ".ren_wen"}, {ren, wen}, {is_load, !is_load});
          if (!is_load) check({name, ".storedata"}, final_storedata, m_sd[k]);
        end
        if (wait_cnt == dly) begin
          check({name, ".addr_hold"}, final_addr, m_addr[k]);
          dhit = 1'b1;
          dload = mem_word(m_addr[k]);
          k++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        lane_en = LANES'($urandom);
        sew = 2'($urandom);
        for (int i = 0; i < LANES; i++) addr[32*i +: 32] = $urandom;
      end
      tick();
      dhit = 1'b0;
      start = 1'b0;
      lat++;
    end
    check({name, ".done_seen"}, seen_done, 1'b1);
    check({name, ".latency"}, lat, int'(m_addr.size()) * (dly + 1) + 1);
    check({name, ".n_access"}, k, m_addr.size());
    if (exp_n >= 0) check({name, ".n_access_plan"}, k, exp_n);
    check({name, ".arrived"}, arrived, en);
    check({name, ".loaddata"}, loaddata, m_load);
    check({name, ".idle_at_done"}, {busy, ren, wen}, 3'b000);
    tick();
    check({name, ".done_pulse"}, done, 1'b0);
  endtask

  typedef struct {
    string                  name;
    bit                     is_load;
    logic [1:0]             s;
    logic [LANES-1:0]       en;
    logic [LANES-1:0][31:0] a;
    logic [LANES-1:0][31:0] sd;
    int                     dly;
    int                     exp_n;
  } vec_t;

  function automatic vec_t mk(input string n, input bit ld, input logic [1:0] s,
                              input logic [LANES-1:0] en, input logic [LANES-1:0][31:0] a,
                              input logic [LANES-1:0][31:0] sd, input int dly, input int exp_n);
    vec_t v;
    v.name = n; v.is_load = ld; v.s = s; v.en = en; v.a = a; v.sd = sd;
    v.dly = dly; v.exp_n = exp_n;
    return v;
  endfunction

  task automatic run_table();
    vec_t tbl[9];
    tbl[0] = mk("ld32_seq", 1'b1, 2'd2, 4'b1111, {32'h10C, 32'h108, 32'h104, 32'h100}, '0, 0, 4);
    tbl[1] = mk("st8_word", 1'b0, 2'd0, 4'b1111, {32'h203, 32'h202, 32'h201, 32'h200},
                {32'h44, 32'h33, 32'h22, 32'h11}, 0, COALESCE ? 1 : 4);
    tbl[2] = mk("ld16_misal", 1'b1, 2'd1, 4'b1111, {32'h306, 32'h301, 32'h302, 32'h300}, '0, 0, 0);
    tbl[3] = mk("ld32_mask", 1'b1, 2'd2, 4'b0101, {32'h40C, 32'h408, 32'h404, 32'h400}, '0, 3, 2);
    tbl[4] = mk("ld8_rot", 1'b1, 2'd0, 4'b1111, {32'h502, 32'h501, 32'h500, 32'h503}, '0, 1,
                COALESCE ? 1 : 4);
    tbl[5] = mk("empty", 1'b1, 2'd2, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, '0, 0, 0);
    tbl[6] = mk("sew_rsv", 1'b0, 2'd3, 4'b0010, {32'h0, 32'h0, 32'h10, 32'h0}, '0, 0, 0);
    tbl[7] = mk("st16_mix", 1'b0, 2'd1, 4'b1111, {32'h60A, 32'h600, 32'h602, 32'h600},
                {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, 1, COALESCE ? 3 : 4);
    tbl[8] = mk("ld32_lowexc", 1'b1, 2'd2, 4'b1110, {32'h2, 32'h8, 32'h5, 32'h3}, '0, 0, 0);
    for (int i = 0; i < 9; i++)
      run_group(tbl[i].name, tbl[i].is_load, tbl[i].s, tbl[i].en, tbl[i].a, tbl[i].sd,
                tbl[i].dly, tbl[i].exp_n, 1'b0);
  endtask

  // Abort after the first hit, with a coincident dhit that must be ignored.
  task automatic returnex_seq();
    load_ena = 1'b1; store_ena = 1'b0; sew = 2'd2; lane_en = 4'b1111;
    addr = {32'h70C, 32'h708, 32'h704, 32'h700}; start = 1'b1;
    tick();
    start = 1'b0;
    check("rx.req0", final_addr, 32'h700);
    dhit = 1'b1; dload = mem_word(32'h700);
    tick();
    dhit = 1'b0;
    check("rx.arrived0", arrived, 4'b0001);
    check("rx.req1", final_addr, 32'h704);
    returnex = 1'b1; dhit = 1'b1; dload = mem_word(32'h704);
    tick();
    returnex = 1'b0; dhit = 1'b0;
    check("rx.idle", {busy, ren, wen, done}, 4'b0000);
    check("rx.arrived_kept", arrived, 4'b0001);
    check("rx.partial_load", loaddata, {96'h0, mem_word(32'h700)});
    tick();
    check("rx.no_done", done, 1'b0);
    run_group("rx.restart", 1'b0, 2'd2, 4'b0011, {32'h0, 32'h0, 32'h784, 32'h780},
              {32'h0, 32'h0, 32'hCAFE_F00D, 32'h1234_5678}, 0, 2, 1'b0);
  endtask

  task automatic reset_seq();
    load_ena = 1'b1; store_ena = 1'b0; sew = 2'd2; lane_en = 4'b1111;
    addr = {32'h80C, 32'h808, 32'h804, 32'h800}; start = 1'b1;
    tick();
    start = 1'b0;
    dhit = 1'b1; dload = mem_word(32'h800);
    tick();
    dhit = 1'b0;
    check("rst.pre_load", loaddata[31:0], mem_word(32'h800));
    check("rst.pre_busy", busy, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst.outputs", {final_addr, final_storedata, byte_ena, ren, wen, loaddata,
                          arrived, busy, done, exception, exc_lane}, 0);
    tick();
    check("rst.stay_idle", {busy, ren, wen, done}, 4'b0000);
  endtask

  task automatic random_seq();
    logic [1:0]             s;
    logic [LANES-1:0]       en;
    logic [LANES-1:0][31:0] a, sd;
    int                     off;
    for (int g = 0; g < 60; g++) begin
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      en = LANES'($urandom);
      for (int i = 0; i < LANES; i++) begin
        off = $urandom_range(0, 3);
        if (s != 2'd3 && $urandom_range(0, 15) != 0) off = off & ~((1 << s) - 1);
        a[i] = 32'h1000 + 32'($urandom_range(0, 1) * 4) + 32'(off);
        sd[i] = $urandom;
      end
      run_group($sformatf("rnd%0d", g), 1'($urandom_range(0, 1)), s, en, a, sd,
                $urandom_range(0, 2), -1, 1'b1);
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; load_ena = 1'b0; store_ena = 1'b0; returnex = 1'b0;
    dhit = 1'b0; sew = 2'd0; lane_en = '0; addr = '0; storedata = '0; dload = '0;
    repeat (3) tick();
    check("reset.outputs", {final_addr, final_storedata, byte_ena, ren, wen, loaddata,
                            arrived, busy, done, exception, exc_lane}, 0);
    RST = 1'b0;
    tick();
    run_table();
    returnex_seq();
    reset_seq();
    random_seq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
